// File: rtl/hatch_sequencer_pkg.sv
// Shared definitions for the hatch sequencer: sequencer state encoding,
// datapath widths, the hatched progress value and a saturating increment.
package hatch_sequencer_pkg;

  localparam int DZ_W  = 5;  // width of the dot-matrix progress index
  localparam int CNT_W = 4;  // width of warm/idle/hatch counters

  localparam logic [DZ_W-1:0] DZ_HATCH = 5'd16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INCUBATE,
    ST_HATCHED,
    ST_FAILED
  } state_t;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (value == {CNT_W{1'b1}}) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/hatch_sequencer_idle_timer.sv
// Idle timer: counts tick pulses since the last clear and flags the tick
// that would reach TIMEOUT.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the count from zero (has priority over tick)
//   tick       : count-enable pulse
//   expire     : combinational, high during the tick that reaches TIMEOUT
//   idle_cnt   : current count, always below TIMEOUT
module idle_timer
  import hatch_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             tick,
  output logic             expire,
  output logic [CNT_W-1:0] idle_cnt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  // Expiry is flagged on the tick itself so the caller can register the
  // failure on the same edge that counts the final tick.
  assign expire = tick && !clear && (idle_cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (clear || expire) begin
      // Returning to zero on expiry keeps the count from ever wrapping.
      idle_cnt <= '0;
    end else if (tick) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hatch_sequencer.sv
// Hatch sequencer: egg incubation game controller. Warm pulses advance a
// 0..16 progress index; too many ticks without warming fail the egg.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin/restart incubation (ignored while incubating)
//   warm       : player warms the egg
//   tick       : 1 Hz enable pulse
//   dz_num     : progress index, 16 = hatched
//   dz_load    : one-cycle strobe when dz_num/fail change
//   fail       : high while failed
//   done       : high while hatched
//   hatch_cnt  : successful hatches since reset, saturating at 15
module hatch_sequencer
  import hatch_sequencer_pkg::*;
#(
  parameter int WARM_PER_STEP = 2,
  parameter int TIMEOUT       = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             warm,
  input  logic             tick,
  output logic [DZ_W-1:0]  dz_num,
  output logic             dz_load,
  output logic             fail,
  output logic             done,
  output logic [CNT_W-1:0] hatch_cnt
);

  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARM_PER_STEP - 1);

  state_t           state_q, state_d;
  logic [DZ_W-1:0]  dz_num_q, dz_num_d;
  logic             dz_load_q, dz_load_d;
  logic             fail_q, fail_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] hatch_cnt_q, hatch_cnt_d;
  logic [CNT_W-1:0] warm_cnt_q, warm_cnt_d;

  logic             timer_clear;
  logic             timer_tick;
  logic             timer_expire;
  logic [CNT_W-1:0] idle_cnt;

  // Timer controls are derived straight from state and inputs, not from the
  // next-state block, so expire never feeds back into its own enable.
  // Warm wins over a simultaneous tick: it clears and the tick is dropped.
  assign timer_clear = (state_q == ST_INCUBATE) ? warm : start;
  assign timer_tick  = (state_q == ST_INCUBATE) && tick && !warm;

  idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (timer_clear),
    .tick     (timer_tick),
    .expire   (timer_expire),
    .idle_cnt (idle_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      dz_num_q    <= '0;
      dz_load_q   <= 1'b0;
      fail_q      <= 1'b0;
      done_q      <= 1'b0;
      hatch_cnt_q <= '0;
      warm_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      dz_num_q    <= dz_num_d;
      dz_load_q   <= dz_load_d;
      fail_q      <= fail_d;
      done_q      <= done_d;
      hatch_cnt_q <= hatch_cnt_d;
      warm_cnt_q  <= warm_cnt_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    dz_num_d    = dz_num_q;
    dz_load_d   = 1'b0;
    fail_d      = fail_q;
    done_d      = done_q;
    hatch_cnt_d = hatch_cnt_q;
    warm_cnt_d  = warm_cnt_q;

    unique case (state_q)
      ST_INCUBATE: begin
        if (warm) begin
          if (warm_cnt_q == WARM_LAST) begin
            warm_cnt_d = '0;
            dz_num_d   = dz_num_q + 1'b1;
            dz_load_d  = 1'b1;
            if (dz_num_q + 1'b1 == DZ_HATCH) begin
              state_d     = ST_HATCHED;
              done_d      = 1'b1;
              hatch_cnt_d = sat_inc(hatch_cnt_q);
            end
          end else begin
            warm_cnt_d = warm_cnt_q + 1'b1;
          end
        end else if (timer_expire) begin
          state_d   = ST_FAILED;
          fail_d    = 1'b1;
          dz_load_d = 1'b1;
        end
      end

      // Idle, hatched and failed all react only to start, with identical
      // entry into incubation; warm and tick are ignored.
      ST_IDLE, ST_HATCHED, ST_FAILED: begin
        if (start) begin
          state_d    = ST_INCUBATE;
          dz_num_d   = '0;
          warm_cnt_d = '0;
          dz_load_d  = 1'b1;
          fail_d     = 1'b0;
          done_d     = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign dz_num    = dz_num_q;
  assign dz_load   = dz_load_q;
  assign fail      = fail_q;
  assign done      = done_q;
  assign hatch_cnt = hatch_cnt_q;

endmodule

// File: tb/tb_hatch_sequencer.sv
// Directed testbench for hatch_sequencer with default parameters
// (WARM_PER_STEP = 2, TIMEOUT = 5).
module tb_hatch_sequencer;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       warm  = 1'b0;
  logic       tick  = 1'b0;
  logic [4:0] dz_num;
  logic       dz_load;
  logic       fail;
  logic       done;
  logic [3:0] hatch_cnt;

  int n_checks  = 0;
  int n_fail    = 0;
  int load_seen = 0;

  always #5 clk = ~clk;

  hatch_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .warm      (warm),
    .tick      (tick),
    .dz_num    (dz_num),
    .dz_load   (dz_load),
    .fail      (fail),
    .done      (done),
    .hatch_cnt (hatch_cnt)
  );

  // One clock cycle: inputs applied at the falling edge, captured by the
  // rising edge, outputs observed 1 ns later.
  task automatic step(input logic s, input logic w, input logic t);
    @(negedge clk);
    start = s;
    warm  = w;
    tick  = t;
    @(posedge clk);
    #1;
    start = 1'b0;
    warm  = 1'b0;
    tick  = 1'b0;
    if (dz_load) load_seen++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b1;
    warm  = 1'b1;
    tick  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (dz_num !== 5'd0) begin n_fail++; $display("FAIL reset_dz_num: got %0d expected 0", dz_num); end
    n_checks++; if (dz_load !== 1'b0) begin n_fail++; $display("FAIL reset_dz_load: got %b expected 0", dz_load); end
    n_checks++; if (fail !== 1'b0) begin n_fail++; $display("FAIL reset_fail: got %b expected 0", fail); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (hatch_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_hatch_cnt: got %0d expected 0", hatch_cnt); end
    start = 1'b0;
    warm  = 1'b0;
    tick  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    n_checks++; if (dz_load !== 1'b0) begin n_fail++; $display("FAIL reset_release_load: got %b expected 0", dz_load); end
    // warm and tick in IDLE do nothing
    step(1'b0, 1'b1, 1'b1);
    n_checks++; if (dz_num !== 5'd0 || dz_load !== 1'b0 || fail !== 1'b0) begin
      n_fail++; $display("FAIL idle_ignore: got dz_num=%0d load=%b fail=%b expected 0/0/0", dz_num, dz_load, fail);
    end
  endtask

  task automatic test_full_hatch;
    load_seen = 0;
    step(1'b1, 1'b0, 1'b0);
    n_checks++; if (dz_num !== 5'd0 || dz_load !== 1'b1) begin
      n_fail++; $display("FAIL start_load: got dz_num=%0d load=%b expected 0/1", dz_num, dz_load);
    end
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b1, 1'b0);
      n_checks++; if (dz_num !== 5'(i - 1) || dz_load !== 1'b0) begin
        n_fail++; $display("FAIL half_step_%0d: got dz_num=%0d load=%b expected %0d/0", i, dz_num, dz_load, i - 1);
      end
      step(1'b0, 1'b1, 1'b0);
      n_checks++; if (dz_num !== 5'(i) || dz_load !== 1'b1 || done !== (i == 16)) begin
        n_fail++; $display("FAIL full_step_%0d: got dz_num=%0d load=%b done=%b expected %0d/1/%b",
                           i, dz_num, dz_load, done, i, i == 16);
      end
    end
    n_checks++; if (load_seen !== 17) begin n_fail++; $display("FAIL hatch_load_count: got %0d expected 17", load_seen); end
    n_checks++; if (hatch_cnt !== 4'd1) begin n_fail++; $display("FAIL hatch_cnt_one: got %0d expected 1", hatch_cnt); end
    step(1'b0, 1'b0, 1'b0);
    n_checks++; if (dz_load !== 1'b0 || done !== 1'b1) begin
      n_fail++; $display("FAIL hatched_hold: got load=%b done=%b expected 0/1", dz_load, done);
    end
    step(1'b0, 1'b1, 1'b1);
    n_checks++; if (dz_num !== 5'd16 || dz_load !== 1'b0 || fail !== 1'b0) begin
      n_fail++; $display("FAIL hatched_ignore: got dz_num=%0d load=%b fail=%b expected 16/0/0", dz_num, dz_load, fail);
    end
  endtask

  task automatic test_restart_hatched;
    step(1'b1, 1'b0, 1'b0);
    n_checks++; if (dz_num !== 5'd0 || done !== 1'b0 || dz_load !== 1'b1) begin
      n_fail++; $display("FAIL restart_hatched: got dz_num=%0d done=%b load=%b expected 0/0/1", dz_num, done, dz_load);
    end
    n_checks++; if (hatch_cnt !== 4'd1) begin n_fail++; $display("FAIL restart_keeps_cnt: got %0d expected 1", hatch_cnt); end
  endtask

  task automatic test_timeout;
    repeat (3) step(1'b0, 1'b1, 1'b0);
    n_checks++; if (dz_num !== 5'd1) begin n_fail++; $display("FAIL timeout_warms: got dz_num=%0d expected 1", dz_num); end
    load_seen = 0;
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 1'b0, 1'b1);
      n_checks++; if (fail !== 1'b0 || dz_load !== 1'b0) begin
        n_fail++; $display("FAIL timeout_tick_%0d: got fail=%b load=%b expected 0/0", i, fail, dz_load);
      end
    end
    step(1'b0, 1'b0, 1'b1);
    n_checks++; if (fail !== 1'b1 || dz_load !== 1'b1 || dz_num !== 5'd1) begin
      n_fail++; $display("FAIL timeout_fifth: got fail=%b load=%b dz_num=%0d expected 1/1/1", fail, dz_load, dz_num);
    end
    repeat (2) step(1'b0, 1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b1);
    n_checks++; if (fail !== 1'b1 || dz_num !== 5'd1 || dz_load !== 1'b0) begin
      n_fail++; $display("FAIL failed_ignore: got fail=%b dz_num=%0d load=%b expected 1/1/0", fail, dz_num, dz_load);
    end
    n_checks++; if (load_seen !== 1) begin n_fail++; $display("FAIL timeout_load_count: got %0d expected 1", load_seen); end
  endtask

  task automatic test_warm_tick;
    step(1'b1, 1'b0, 1'b0);
    n_checks++; if (fail !== 1'b0 || dz_num !== 5'd0 || dz_load !== 1'b1) begin
      n_fail++; $display("FAIL restart_failed: got fail=%b dz_num=%0d load=%b expected 0/0/1", fail, dz_num, dz_load);
    end
    repeat (4) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b1);
    n_checks++; if (fail !== 1'b0) begin n_fail++; $display("FAIL warm_tick_no_fail: got fail=%b expected 0", fail); end
    step(1'b0, 1'b0, 1'b1);
    n_checks++; if (fail !== 1'b1 || dz_num !== 5'd0) begin
      n_fail++; $display("FAIL warm_tick_fifth: got fail=%b dz_num=%0d expected 1/0", fail, dz_num);
    end
  endtask

  task automatic test_reset_mid;
    step(1'b1, 1'b0, 1'b0);
    repeat (14) step(1'b0, 1'b1, 1'b0);
    n_checks++; if (dz_num !== 5'd7) begin n_fail++; $display("FAIL mid_progress: got dz_num=%0d expected 7", dz_num); end
    step(1'b1, 1'b0, 1'b0);
    n_checks++; if (dz_num !== 5'd7 || dz_load !== 1'b0) begin
      n_fail++; $display("FAIL start_ignored: got dz_num=%0d load=%b expected 7/0", dz_num, dz_load);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (dz_num !== 5'd0 || dz_load !== 1'b0 || fail !== 1'b0 || done !== 1'b0 || hatch_cnt !== 4'd0) begin
      n_fail++; $display("FAIL async_reset: got dz_num=%0d load=%b fail=%b done=%b hatch_cnt=%0d expected all 0",
                         dz_num, dz_load, fail, done, hatch_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    n_checks++; if (dz_num !== 5'd0 || dz_load !== 1'b0) begin
      n_fail++; $display("FAIL after_reset_idle: got dz_num=%0d load=%b expected 0/0", dz_num, dz_load);
    end
  endtask

  task automatic test_saturate;
    for (int h = 1; h <= 16; h++) begin
      step(1'b1, 1'b0, 1'b0);
      repeat (32) step(1'b0, 1'b1, 1'b0);
      n_checks++; if (done !== 1'b1 || hatch_cnt !== 4'((h > 15) ? 15 : h)) begin
        n_fail++; $display("FAIL saturate_%0d: got done=%b hatch_cnt=%0d expected 1/%0d",
                           h, done, hatch_cnt, (h > 15) ? 15 : h);
      end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_hatch();
    test_restart_hatched();
    test_timeout();
    test_warm_tick();
    test_reset_mid();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
